// File: rtl/resample_pkg.sv
// resample_pkg
// Shared definitions for the resample engine: FSM state encodings, the
// interpolation mode encodings and the pixel-memory address-width helper.
package resample_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Interpolation mode encodings (value of in_mode)
  localparam logic MODE_NEAREST  = 1'b0;
  localparam logic MODE_BILINEAR = 1'b1;

  // Bits needed to address a w x h image with ch interleaved components
  function automatic int addr_width(input int w, input int h, input int ch);
    int n;
    n = w * h * ch;
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/resample_engine_bilin_weight.sv
// bilin_weight
// Combinational bilinear weight generator. With S = 2^PRECISION:
//   k=0: (S-a)(S-b)   k=1: a(S-b)   k=2: (S-a)b   k=3: ab
// In nearest mode the single read carries the full weight S^2.
// Ports:
//   a, b  in  PRECISION   fractional X / Y position
//   k     in  2           neighbour index (bit0 selects x1, bit1 selects y1)
//   mode  in  1           MODE_NEAREST / MODE_BILINEAR
//   w     out 2*PRECISION+1  weight for neighbour k
module bilin_weight
  import resample_pkg::*;
#(
  parameter int PRECISION = 16
) (
  input  logic [PRECISION-1:0]   a,
  input  logic [PRECISION-1:0]   b,
  input  logic [1:0]             k,
  input  logic                   mode,
  output logic [2*PRECISION:0]   w
);

  localparam int FW = PRECISION + 1;
  localparam int WW = 2 * PRECISION + 1;
  // S^2: full weight of a single nearest-neighbour read
  localparam logic [WW-1:0] W_NEAR = {1'b1, {(2*PRECISION){1'b0}}};

  logic [FW-1:0]   s_s;
  logic [FW-1:0]   fa_s;
  logic [FW-1:0]   fb_s;
  logic [FW-1:0]   sa_s;
  logic [FW-1:0]   sb_s;
  logic [2*FW-1:0] prod_s;
  logic            unused_s;

  // S is exact (1 followed by PRECISION zeros), so S-a ranges 1..S
  assign s_s  = {1'b1, {PRECISION{1'b0}}};
  assign fa_s = {1'b0, a};
  assign fb_s = {1'b0, b};
  assign sa_s = s_s - fa_s;
  assign sb_s = s_s - fb_s;

  // Select the factor pair for neighbour k and apply the nearest override
  always_comb begin
    prod_s = {(2*FW){1'b0}};
    case (k)
      2'd0:    prod_s = {{FW{1'b0}}, sa_s} * {{FW{1'b0}}, sb_s};
      2'd1:    prod_s = {{FW{1'b0}}, fa_s} * {{FW{1'b0}}, sb_s};
      2'd2:    prod_s = {{FW{1'b0}}, sa_s} * {{FW{1'b0}}, fb_s};
      2'd3:    prod_s = {{FW{1'b0}}, fa_s} * {{FW{1'b0}}, fb_s};
      default: prod_s = {(2*FW){1'b0}};
    endcase
    if (mode == MODE_NEAREST) begin
      w = W_NEAR;
    end else begin
      // Largest product is S^2, which fits in 2*PRECISION+1 bits
      w = prod_s[WW-1:0];
    end
  end

  assign unused_s = prod_s[2*FW-1];

endmodule

// File: rtl/resample_engine.sv
// resample_engine
// Per-request resampler: reads the 2x2 neighbourhood (or one nearest pixel)
// of each channel from a synchronous pixel memory, accumulates the weighted
// sum and emits one rounded pixel per channel.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready              request handshake
//   in_x, in_y, in_a, in_b, in_mode  integer/fractional position and mode
//   mem_rd, mem_addr, mem_data     pixel memory (data one cycle after mem_rd)
//   out_valid/out_ready            result handshake
//   out_pix, out_ch, out_last      result, channel index, last-channel flag
module resample_engine
  import resample_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 8,
  parameter int PRECISION = 16,
  parameter int W_IN      = 200,
  parameter int H_IN      = 200,
  parameter int CHANNEL   = 1,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = addr_width(W_IN, H_IN, CHANNEL)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_x,
  input  logic [M-1:0]         in_y,
  input  logic [PRECISION-1:0] in_a,
  input  logic [PRECISION-1:0] in_b,
  input  logic                 in_mode,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]     mem_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_pix,
  output logic [1:0]           out_ch,
  output logic                 out_last
);

  localparam int WW   = 2 * PRECISION + 1;
  localparam int AW   = 2 * PRECISION + PIX_W + 1;
  localparam int XMAX = W_IN - 1;
  localparam int YMAX = H_IN - 1;
  localparam logic [AW-1:0] HALF    = {{(AW-2*PRECISION){1'b0}}, 1'b1, {(2*PRECISION-1){1'b0}}};
  localparam logic [1:0]    CH_LAST = 2'(CHANNEL - 1);

  state_t                 state_r;
  logic [N-1:0]           x0_r, x1_r;
  logic [M-1:0]           y0_r, y1_r;
  logic [PRECISION-1:0]   a_r, b_r;
  logic                   mode_r;
  logic [1:0]             c_r;
  logic [1:0]             k_r;
  logic [1:0]             rd_k_r;
  logic                   rd_pend_r;
  logic [AW-1:0]          acc_r;
  logic                   in_ready_r;
  logic                   mem_rd_r;
  logic [ADDR_W-1:0]      mem_addr_r;
  logic                   out_valid_r;
  logic [PIX_W-1:0]       out_pix_r;
  logic [1:0]             out_ch_r;
  logic                   out_last_r;

  logic [N-1:0]           in_x0_s, in_x1_s, sel_x0_s, sel_x1_s, rd_x_s;
  logic [M-1:0]           in_y0_s, in_y1_s, sel_y0_s, sel_y1_s, rd_y_s;
  logic [1:0]             issue_k_s;
  logic [1:0]             issue_c_s;
  logic [31:0]            addr_full_s;
  logic [WW-1:0]          w_s;
  logic                   first_s;
  logic [AW-1:0]          prod_s;
  logic [AW-1:0]          acc_next_s;
  logic [AW-1:0]          rnd_s;
  logic                   unused_s;

  assign in_ready  = in_ready_r;
  assign mem_rd    = mem_rd_r;
  assign mem_addr  = mem_addr_r;
  assign out_valid = out_valid_r;
  assign out_pix   = out_pix_r;
  assign out_ch    = out_ch_r;
  assign out_last  = out_last_r;

  // Clamp the incoming coordinate; at the border the +1 neighbour folds back
  always_comb begin
    if (int'(in_x) > XMAX) begin
      in_x0_s = N'(XMAX);
    end else begin
      in_x0_s = in_x;
    end
    if (int'(in_x0_s) + 1 > XMAX) begin
      in_x1_s = in_x0_s;
    end else begin
      in_x1_s = in_x0_s + {{(N-1){1'b0}}, 1'b1};
    end
    if (int'(in_y) > YMAX) begin
      in_y0_s = M'(YMAX);
    end else begin
      in_y0_s = in_y;
    end
    if (int'(in_y0_s) + 1 > YMAX) begin
      in_y1_s = in_y0_s;
    end else begin
      in_y1_s = in_y0_s + {{(M-1){1'b0}}, 1'b1};
    end
  end

  // Pick neighbour index, channel and coordinate source for the next read.
  // Nearest mode reuses the neighbour index {b_msb, a_msb}.
  always_comb begin
    sel_x0_s  = x0_r;
    sel_x1_s  = x1_r;
    sel_y0_s  = y0_r;
    sel_y1_s  = y1_r;
    issue_k_s = k_r + 2'd1;
    issue_c_s = c_r;
    case (state_r)
      ST_IDLE: begin
        sel_x0_s  = in_x0_s;
        sel_x1_s  = in_x1_s;
        sel_y0_s  = in_y0_s;
        sel_y1_s  = in_y1_s;
        issue_k_s = (in_mode == MODE_BILINEAR) ? 2'd0 : {in_b[PRECISION-1], in_a[PRECISION-1]};
        issue_c_s = 2'd0;
      end
      ST_OUT: begin
        issue_k_s = (mode_r == MODE_BILINEAR) ? 2'd0 : {b_r[PRECISION-1], a_r[PRECISION-1]};
        issue_c_s = c_r + 2'd1;
      end
      default: begin
        issue_k_s = k_r + 2'd1;
        issue_c_s = c_r;
      end
    endcase
    rd_x_s      = issue_k_s[0] ? sel_x1_s : sel_x0_s;
    rd_y_s      = issue_k_s[1] ? sel_y1_s : sel_y0_s;
    addr_full_s = (32'(rd_y_s) * 32'(W_IN) + 32'(rd_x_s)) * 32'(CHANNEL) + 32'(issue_c_s);
  end

  bilin_weight #(
    .PRECISION (PRECISION)
  ) u_weight (
    .a    (a_r),
    .b    (b_r),
    .k    (rd_k_r),
    .mode (mode_r),
    .w    (w_s)
  );

  // Weighted accumulation of the pixel returned for the previous read
  always_comb begin
    first_s = (mode_r == MODE_NEAREST) || (rd_k_r == 2'd0);
    prod_s  = AW'(w_s) * AW'(mem_data);
    if (!rd_pend_r) begin
      acc_next_s = acc_r;
    end else if (first_s) begin
      acc_next_s = prod_s;
    end else begin
      acc_next_s = acc_r + prod_s;
    end
    // Weights sum to S^2, so the rounded quotient always fits PIX_W bits
    rnd_s = acc_next_s + HALF;
  end

  // Request controller, read sequencer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      x0_r        <= '0;
      x1_r        <= '0;
      y0_r        <= '0;
      y1_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      mode_r      <= MODE_NEAREST;
      c_r         <= 2'd0;
      k_r         <= 2'd0;
      rd_k_r      <= 2'd0;
      rd_pend_r   <= 1'b0;
      acc_r       <= '0;
      in_ready_r  <= 1'b1;
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= '0;
      out_valid_r <= 1'b0;
      out_pix_r   <= '0;
      out_ch_r    <= 2'd0;
      out_last_r  <= 1'b0;
    end else begin
      // Data for a read issued last cycle is consumed this cycle
      rd_pend_r <= mem_rd_r;
      rd_k_r    <= k_r;
      acc_r     <= acc_next_s;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            x0_r       <= in_x0_s;
            x1_r       <= in_x1_s;
            y0_r       <= in_y0_s;
            y1_r       <= in_y1_s;
            a_r        <= in_a;
            b_r        <= in_b;
            mode_r     <= in_mode;
            c_r        <= 2'd0;
            k_r        <= issue_k_s;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= addr_full_s[ADDR_W-1:0];
            in_ready_r <= 1'b0;
            state_r    <= ST_ISSUE;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if ((mode_r == MODE_BILINEAR) && (k_r != 2'd3)) begin
            k_r        <= issue_k_s;
            mem_rd_r   <= 1'b1;
            mem_addr_r <= addr_full_s[ADDR_W-1:0];
          end else begin
            mem_rd_r   <= 1'b0;
            state_r    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          out_valid_r <= 1'b1;
          out_pix_r   <= rnd_s[2*PRECISION +: PIX_W];
          out_ch_r    <= c_r;
          out_last_r  <= (c_r == CH_LAST);
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (c_r != CH_LAST) begin
              c_r        <= issue_c_s;
              k_r        <= issue_k_s;
              mem_rd_r   <= 1'b1;
              mem_addr_r <= addr_full_s[ADDR_W-1:0];
              state_r    <= ST_ISSUE;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= ST_IDLE;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          mem_rd_r    <= 1'b0;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign unused_s = ^{addr_full_s, rnd_s};

endmodule

// File: tb/tb_resample_engine.sv
// Directed bench for resample_engine: a single-channel 200x200 instance (A)
// and a three-channel 8x8 instance (B), each with a synchronous memory model.
module tb_resample_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- instance A: CHANNEL=1, 200x200 ----------------
  logic        a_in_valid, a_in_ready, a_in_mode, a_mem_rd;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_x, a_in_y, a_mem_data, a_out_pix;
  logic [15:0] a_in_a, a_in_b, a_mem_addr;
  logic [1:0]  a_out_ch;
  logic [7:0]  mem_a [0:39999];

  resample_engine u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_x(a_in_x), .in_y(a_in_y), .in_a(a_in_a), .in_b(a_in_b), .in_mode(a_in_mode),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pix(a_out_pix), .out_ch(a_out_ch), .out_last(a_out_last)
  );

  always @(posedge clk) if (a_mem_rd) a_mem_data <= mem_a[a_mem_addr];

  // ---------------- instance B: CHANNEL=3, 8x8 ----------------
  logic        b_in_valid, b_in_ready, b_in_mode, b_mem_rd;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_x, b_in_y, b_mem_data, b_out_pix, b_mem_addr;
  logic [15:0] b_in_a, b_in_b;
  logic [1:0]  b_out_ch;
  logic [7:0]  mem_b [0:191];

  resample_engine #(.W_IN(8), .H_IN(8), .CHANNEL(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_x(b_in_x), .in_y(b_in_y), .in_a(b_in_a), .in_b(b_in_b), .in_mode(b_in_mode),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pix(b_out_pix), .out_ch(b_out_ch), .out_last(b_out_last)
  );

  always @(posedge clk) if (b_mem_rd) b_mem_data <= mem_b[b_mem_addr];

  logic [15:0] rd_addr [0:7];

  // Drive one request into A, collect read addresses, latency (edges after
  // the acceptance edge until out_valid is seen) and the result, then accept it.
  task automatic do_req_a(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] fa, input logic [15:0] fb, input logic mode,
                          output int lat, output logic [7:0] pix, output logic last,
                          output int nrd);
    @(posedge clk); #1;
    a_in_x = x; a_in_y = y; a_in_a = fa; a_in_b = fb; a_in_mode = mode;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0; nrd = 0;
    while (!a_out_valid && lat < 30) begin
      if (a_mem_rd) begin
        if (nrd < 8) rd_addr[nrd] = a_mem_addr;
        nrd++;
      end
      @(posedge clk); #1;
      lat++;
    end
    pix  = a_out_pix;
    last = a_out_last;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_in_ready, a_mem_rd, a_mem_addr, a_out_valid, a_out_pix, a_out_ch, a_out_last}
        !== {1'b1, 1'b0, 16'd0, 1'b0, 8'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: rdy=%0b rd=%0b addr=%0d ov=%0b pix=%0d ch=%0d last=%0b, required rdy=1 others 0",
               a_in_ready, a_mem_rd, a_mem_addr, a_out_valid, a_out_pix, a_out_ch, a_out_last);
    end
    n_tests++;
    if ({b_in_ready, b_mem_rd, b_mem_addr, b_out_valid, b_out_pix, b_out_ch, b_out_last}
        !== {1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: rdy=%0b rd=%0b ov=%0b, required rdy=1 others 0",
               b_in_ready, b_mem_rd, b_out_valid);
    end
  endtask

  task automatic test_bilinear();
    int lat, nrd;
    logic [7:0] pix;
    logic last;
    logic [15:0] exp_addr [0:3];
    exp_addr[0] = 16'd1405; exp_addr[1] = 16'd1406;  // (7*200+5), (7*200+6)
    exp_addr[2] = 16'd1605; exp_addr[3] = 16'd1606;  // (8*200+5), (8*200+6)
    // Centre of 10/20/30/40 -> 25
    do_req_a(8'd5, 8'd7, 16'h8000, 16'h8000, 1'b1, lat, pix, last, nrd);
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL bil_latency: got %0d required 5", lat); end
    n_tests++;
    if (pix !== 8'd25) begin n_fail++; $display("FAIL bil_mid_pix: got %0d required 25", pix); end
    n_tests++;
    if (last !== 1'b1) begin n_fail++; $display("FAIL bil_last: got %0b required 1", last); end
    n_tests++;
    if (nrd !== 4) begin n_fail++; $display("FAIL bil_nreads: got %0d required 4", nrd); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_addr[i] !== exp_addr[i]) begin
        n_fail++;
        $display("FAIL bil_addr%0d: got %0d required %0d", i, rd_addr[i], exp_addr[i]);
      end
    end
    // a=b=0: result is exactly the (x0,y0) pixel
    do_req_a(8'd5, 8'd7, 16'h0000, 16'h0000, 1'b1, lat, pix, last, nrd);
    n_tests++;
    if (pix !== 8'd10) begin n_fail++; $display("FAIL bil_zero_frac: got %0d required 10", pix); end
    // a=b=0xFFFF, only (x1,y1)=255: acc = 255*65535^2, plus 2^31, >>32 = 255
    do_req_a(8'd20, 8'd30, 16'hFFFF, 16'hFFFF, 1'b1, lat, pix, last, nrd);
    n_tests++;
    if (pix !== 8'd255) begin n_fail++; $display("FAIL bil_max_frac: got %0d required 255", pix); end
  endtask

  task automatic test_nearest();
    int lat, nrd;
    logic [7:0] pix;
    logic last;
    // a MSB set, b MSB clear -> single read of (x1,y0) = 1406 holding 20
    do_req_a(8'd5, 8'd7, 16'h8000, 16'h7FFF, 1'b0, lat, pix, last, nrd);
    n_tests++;
    if (lat !== 2) begin n_fail++; $display("FAIL near_latency: got %0d required 2", lat); end
    n_tests++;
    if (nrd !== 1) begin n_fail++; $display("FAIL near_nreads: got %0d required 1", nrd); end
    n_tests++;
    if (rd_addr[0] !== 16'd1406) begin n_fail++; $display("FAIL near_addr: got %0d required 1406", rd_addr[0]); end
    n_tests++;
    if (pix !== 8'd20) begin n_fail++; $display("FAIL near_pix: got %0d required 20", pix); end
  endtask

  task automatic test_edge();
    int lat, nrd;
    logic [7:0] pix;
    logic last;
    // Bottom-right corner: every neighbour clamps to 199*200+199 = 39999
    do_req_a(8'd199, 8'd199, 16'h1234, 16'hABCD, 1'b1, lat, pix, last, nrd);
    n_tests++;
    if (nrd !== 4) begin n_fail++; $display("FAIL edge_nreads: got %0d required 4", nrd); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (rd_addr[i] !== 16'd39999) begin
        n_fail++;
        $display("FAIL edge_addr%0d: got %0d required 39999", i, rd_addr[i]);
      end
    end
    n_tests++;
    if (pix !== 8'd77) begin n_fail++; $display("FAIL edge_pix: got %0d required 77", pix); end
    // Out-of-range coordinates clamp to the same corner in nearest mode
    do_req_a(8'd250, 8'd240, 16'hFFFF, 16'hFFFF, 1'b0, lat, pix, last, nrd);
    n_tests++;
    if (rd_addr[0] !== 16'd39999) begin n_fail++; $display("FAIL clamp_addr: got %0d required 39999", rd_addr[0]); end
    n_tests++;
    if (pix !== 8'd77) begin n_fail++; $display("FAIL clamp_pix: got %0d required 77", pix); end
  endtask

  task automatic test_multichannel();
    int lat;
    logic [7:0] pix0;
    logic [1:0] ch0;
    logic last0;
    int unstable;
    // x=2,y=3 on 8x8x3: neighbour bases 78,81,102,105 (mem_b[i]=i) -> avg 91.5+c -> 92+c
    @(posedge clk); #1;
    b_in_x = 8'd2; b_in_y = 8'd3; b_in_a = 16'h8000; b_in_b = 16'h8000; b_in_mode = 1'b1;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      lat = 0;
      while (!b_out_valid && lat < 30) begin
        @(posedge clk); #1;
        lat++;
      end
      n_tests++;
      if (lat !== 5) begin n_fail++; $display("FAIL mc_latency ch%0d: got %0d required 5", c, lat); end
      pix0 = b_out_pix; ch0 = b_out_ch; last0 = b_out_last;
      unstable = 0;
      for (int s = 0; s < 5; s++) begin
        @(posedge clk); #1;
        if (!b_out_valid || b_out_pix !== pix0 || b_out_ch !== ch0 || b_out_last !== last0 || b_mem_rd)
          unstable++;
      end
      n_tests++;
      if (unstable !== 0) begin n_fail++; $display("FAIL mc_stall_stable ch%0d: %0d unstable cycles, required 0", c, unstable); end
      n_tests++;
      if (pix0 !== 8'(92 + c)) begin n_fail++; $display("FAIL mc_pix ch%0d: got %0d required %0d", c, pix0, 92 + c); end
      n_tests++;
      if (ch0 !== 2'(c)) begin n_fail++; $display("FAIL mc_ch: got %0d required %0d", ch0, c); end
      n_tests++;
      if (last0 !== (c == 2)) begin n_fail++; $display("FAIL mc_last ch%0d: got %0b required %0b", c, last0, (c == 2)); end
      n_tests++;
      if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL mc_busy ch%0d: in_ready got %0b required 0", c, b_in_ready); end
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
    end
    n_tests++;
    if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL mc_ready_return: got %0b required 1", b_in_ready); end
  endtask

  task automatic test_reset_midop();
    int lat, nrd, spurious;
    logic [7:0] pix;
    logic last;
    @(posedge clk); #1;
    a_in_x = 8'd5; a_in_y = 8'd7; a_in_a = 16'h8000; a_in_b = 16'h8000; a_in_mode = 1'b1;
    a_in_valid = 1'b1;
    @(posedge clk); #1;          // accepted; first ISSUE cycle
    a_in_valid = 1'b0;
    @(posedge clk); #2;          // second ISSUE cycle
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a_in_ready, a_mem_rd, a_mem_addr, a_out_valid, a_out_pix, a_out_ch, a_out_last}
        !== {1'b1, 1'b0, 16'd0, 1'b0, 8'd0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midop_reset: rdy=%0b rd=%0b addr=%0d ov=%0b, required rdy=1 others 0",
               a_in_ready, a_mem_rd, a_mem_addr, a_out_valid);
    end
    #2;
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_out_valid || a_mem_rd || !a_in_ready) spurious++;
    end
    n_tests++;
    if (spurious !== 0) begin n_fail++; $display("FAIL midop_quiet: %0d active cycles, required 0", spurious); end
    do_req_a(8'd5, 8'd7, 16'h8000, 16'h8000, 1'b1, lat, pix, last, nrd);
    n_tests++;
    if (pix !== 8'd25) begin n_fail++; $display("FAIL midop_after_pix: got %0d required 25", pix); end
    n_tests++;
    if (lat !== 5) begin n_fail++; $display("FAIL midop_after_latency: got %0d required 5", lat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_x = 8'd0; a_in_y = 8'd0; a_in_a = 16'd0; a_in_b = 16'd0;
    a_in_mode = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = 8'd0; b_in_y = 8'd0; b_in_a = 16'd0; b_in_b = 16'd0;
    b_in_mode = 1'b0; b_out_ready = 1'b0;
    for (int i = 0; i < 40000; i++) mem_a[i] = 8'(i * 7);
    for (int i = 0; i < 192; i++) mem_b[i] = 8'(i);
    mem_a[1405] = 8'd10; mem_a[1406] = 8'd20; mem_a[1605] = 8'd30; mem_a[1606] = 8'd40;
    mem_a[6020] = 8'd0;  mem_a[6021] = 8'd0;  mem_a[6220] = 8'd0;  mem_a[6221] = 8'd255;
    mem_a[39999] = 8'd77;
    #1;
    test_reset();
    #22;
    rst = 1'b0;
    test_bilinear();
    test_nearest();
    test_edge();
    test_multichannel();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
